// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
// Every operation takes the same number of cycles: DATA_WIDTH in CALC, one in FIX,
// then a single-cycle DONE pulse. Signs are stripped on entry and restored in FIX.
`timescale 1ns/1ps

module mdu_iterative #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  kill,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]  count;
  logic [2:0]     op;
  logic           sign_a;
  logic           sign_b;
  logic           div_zero;
  // Multiplicand for multiplies, divisor for divides.
  logic [W-1:0]   operand;
  // Product register: upper half accumulates, lower half holds the multiplier.
  logic [2*W-1:0] prod;
  // Dividend shifts out of the MSB while quotient bits enter at the LSB.
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;

  logic           signed_a_op;
  logic           signed_b_op;
  logic           in_sign_a;
  logic           in_sign_b;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;

  logic [W:0]     mul_sum;
  logic [W:0]     trial;
  logic           trial_ge;
  logic [W-1:0]   trial_diff;
  logic           last_iter;

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix;
  logic [W-1:0]   rem_fix;
  logic [W-1:0]   fix_value;

  assign busy      = (state == CALC) || (state == FIX);
  assign done      = (state == DONE);
  assign last_iter = (count == CW'(W - 1));

  // Operand sign handling: MULH/DIV/REM are signed on both sides, MULHSU only on rs1.
  always_comb begin
    signed_b_op = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_a_op = signed_b_op || (funct3 == 3'b010);
    in_sign_a   = signed_a_op & rs1[W-1];
    in_sign_b   = signed_b_op & rs2[W-1];
    mag_a       = in_sign_a ? (~rs1 + 1'b1) : rs1;
    mag_b       = in_sign_b ? (~rs2 + 1'b1) : rs2;
  end

  // One iteration step for each algorithm; the trial subtraction is W+1 bits wide.
  always_comb begin
    mul_sum    = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, operand} : {(W+1){1'b0}});
    trial      = {rem, quot[W-1]};
    trial_ge   = (trial >= {1'b0, operand});
    // When trial >= operand the true difference is below operand, so W bits suffice.
    trial_diff = trial[W-1:0] - operand;
  end

  // Sign restoration and result selection applied in FIX.
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? (~prod + 1'b1) : prod;
    if (div_zero)
      quot_fix = {W{1'b1}};
    else
      quot_fix = (sign_a ^ sign_b) ? (~quot + 1'b1) : quot;
    rem_fix  = sign_a ? (~rem + 1'b1) : rem;
    case (op)
      3'b000:                 fix_value = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: fix_value = prod_fix[2*W-1:W];
      3'b100, 3'b101:         fix_value = quot_fix;
      default:                fix_value = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic; kill aborts CALC/FIX and blocks a start in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && !kill) state_next = CALC;
      CALC: begin
        if (kill)
          state_next = IDLE;
        else if (last_iter)
          state_next = FIX;
      end
      FIX:  state_next = kill ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, write result in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      op       <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      operand  <= '0;
      prod     <= '0;
      quot     <= '0;
      rem      <= '0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !kill) begin
            count    <= '0;
            op       <= funct3;
            sign_a   <= in_sign_a;
            sign_b   <= in_sign_b;
            div_zero <= (rs2 == '0);
            operand  <= funct3[2] ? mag_b : mag_a;
            prod     <= {{W{1'b0}}, mag_b};
            quot     <= mag_a;
            rem      <= '0;
          end
        end
        CALC: begin
          count <= count + 1'b1;
          if (op[2]) begin
            rem  <= trial_ge ? trial_diff : trial[W-1:0];
            quot <= {quot[W-2:0], trial_ge};
          end else begin
            prod <= {mul_sum, prod[W-1:1]};
          end
        end
        FIX: begin
          if (!kill)
            result <= fix_value;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed testbench for mdu_iterative (DATA_WIDTH=32).
// Cycle 0 is the cycle in which start is driven; done is expected in cycle 34.
`timescale 1ns/1ps

module tb_mdu_iterative;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int err_count = 0;
  int chk_count = 0;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  mdu_iterative #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one op; optionally pulse start again at poke_at (must be ignored).
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int poke_at, input string tag);
    @(posedge clk); #1;
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    start = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    for (int c = 1; c <= 34; c++) begin
      if (c == poke_at) begin
        start = 1'b1; funct3 = OP_MUL; rs1 = 32'd100; rs2 = 32'd100;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (c == 1)  check({tag, "_busy_c1"}, {31'd0, busy}, 32'd1);
      if (c == 33) check({tag, "_busy_c33"}, {30'd0, busy, done}, 32'd2);
      if (c == 34) begin
        check({tag, "_done_c34"}, {30'd0, busy, done}, 32'd1);
        check({tag, "_result"}, result, exp);
      end
      if (c < 34) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    $display("op %s f3=%0d a=%h b=%h result=%h expected=%h", tag, f3, a, b, result, exp);
  endtask

  // Issue one op and kill it at kill_at; done must never appear and result must hold.
  task automatic run_kill(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] prior, input int kill_at, input string tag);
    logic saw_done;
    saw_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      kill = (c == kill_at);
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (c == kill_at + 1) check({tag, "_busy_after_kill"}, {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
    end
    kill = 1'b0;
    check({tag, "_no_done"}, {31'd0, saw_done}, 32'd0);
    check({tag, "_result_held"}, result, prior);
    $display("kill %s at cycle %0d result=%h expected=%h", tag, kill_at, result, prior);
  endtask

  // Start a DIV and assert reset asynchronously at cycle rst_at.
  task automatic run_reset(input int rst_at, input string tag);
    @(posedge clk); #1;
    start = 1'b1; funct3 = OP_DIV; rs1 = 32'd1000; rs2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < rst_at; c++) begin
      @(posedge clk); #1;
    end
    check({tag, "_busy_before"}, {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_result"}, result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset %s at cycle %0d busy=%b done=%b result=%h", tag, rst_at, busy, done, result);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; funct3 = 3'd0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, "mul_7_m3");
    run_op(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0, "mulh_min");
    run_op(OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 0, "mulhu_min");
    run_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhsu_ones");
    run_op(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, "div_m7_2");
    run_op(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, "rem_m7_2");
    run_op(OP_DIVU,   32'd100,      32'd7,        32'd14,       0, "divu_100_7");
    run_op(OP_REMU,   32'd100,      32'd7,        32'd2,        0, "remu_100_7");
    run_op(OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 0, "div_by0");
    run_op(OP_REMU,   32'd5,        32'd0,        32'd5,        0, "remu_by0");
    run_op(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, "div_ovf");
    run_op(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        0, "rem_ovf");
    run_op(OP_MUL,    32'd3,        32'd4,        32'd12,       10, "mul_poke");
    run_op(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "mulhu_b2b");
    run_kill(OP_MUL,  32'd5,        32'd5,        32'hFFFFFFFE, 20, "kill_mul");
    run_reset(15, "rst_div");
    run_op(OP_DIVU,   32'd9,        32'd3,        32'd3,        0, "divu_9_3");

    $display("Result: errors=%0d of %0d checks", err_count, chk_count);
    $finish;
  end

endmodule
